// File: rtl/ysyx_23060025_alu_arb_pkg.sv
// ysyx_23060025_alu_arb_pkg: ALU op codes and arbiter state encoding shared by the ALU arbiter slice
package ysyx_23060025_alu_arb_pkg;
  localparam logic [3:0] ALU_OP_ADD           = 4'd0;
  localparam logic [3:0] ALU_OP_SUB           = 4'd1;
  localparam logic [3:0] ALU_OP_AND           = 4'd2;
  localparam logic [3:0] ALU_OP_OR            = 4'd3;
  localparam logic [3:0] ALU_OP_XOR           = 4'd4;
  localparam logic [3:0] ALU_OP_SLL           = 4'd5;
  localparam logic [3:0] ALU_OP_SRL           = 4'd6;
  localparam logic [3:0] ALU_OP_SRA           = 4'd7;
  localparam logic [3:0] ALU_OP_LESS_SIGNED   = 4'd8;
  localparam logic [3:0] ALU_OP_LESS_UNSIGNED = 4'd9;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_RESP = 1'b1} arb_state_e;
endpackage

// File: rtl/ysyx_23060025_alu.sv
// ysyx_23060025_alu: combinational ALU (src1, src2, op -> result, less, zero); undefined ops give result 0
module ysyx_23060025_alu
  import ysyx_23060025_alu_arb_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] src1,
  input  logic [DATA_LEN-1:0] src2,
  input  logic [3:0]          op,
  output logic [DATA_LEN-1:0] result,
  output logic                less,
  output logic                zero
);
  localparam int SW = $clog2(DATA_LEN);
  logic [SW-1:0] sh;
  logic lt_s, lt_u;
  assign sh = src2[SW-1:0];
  assign lt_u = src1 < src2;
  assign lt_s = $signed(src1) < $signed(src2);
  // Outside signed compare the flag is the unsigned borrow of src1 - src2
  assign less = op == ALU_OP_LESS_SIGNED ? lt_s : lt_u;
  assign zero = src1 == src2;
  always_comb begin
    result = '0;
    case (op)
      ALU_OP_ADD:           result = src1 + src2;
      ALU_OP_SUB:           result = src1 - src2;
      ALU_OP_AND:           result = src1 & src2;
      ALU_OP_OR:            result = src1 | src2;
      ALU_OP_XOR:           result = src1 ^ src2;
      ALU_OP_SLL:           result = src1 << sh;
      ALU_OP_SRL:           result = src1 >> sh;
      ALU_OP_SRA:           result = $unsigned($signed(src1) >>> sh);
      ALU_OP_LESS_SIGNED:   result = {{(DATA_LEN-1){1'b0}}, lt_s};
      ALU_OP_LESS_UNSIGNED: result = {{(DATA_LEN-1){1'b0}}, lt_u};
      default:              result = '0;
    endcase
  end
endmodule

// File: rtl/ysyx_23060025_rr_pick.sv
// ysyx_23060025_rr_pick: round-robin picker (req, last -> one-hot grant, idx, any), scanning from last+1
module ysyx_23060025_rr_pick #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] k;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    k = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last) + i) % N);
      if (!any && req[k]) begin
        any = 1'b1;
        grant[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/ysyx_23060025_alu_arb.sv
// ysyx_23060025_alu_arb: round-robin sharing of one ALU among NUM_REQ valid/ready requesters, 1-cycle registered response
module ysyx_23060025_alu_arb
  import ysyx_23060025_alu_arb_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int NUM_REQ  = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_src1_i,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_src2_i,
  input  logic [NUM_REQ*4-1:0]        req_op_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  input  logic [NUM_REQ-1:0]          rsp_ready_i,
  output logic [DATA_LEN-1:0]         rsp_result_o,
  output logic                        rsp_less_o,
  output logic                        rsp_zero_o
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  arb_state_e state, state_nxt;
  logic [IW-1:0] owner, last_grant, g_idx;
  logic [NUM_REQ-1:0] g_hot;
  logic g_any, can_accept, accept;
  logic [DATA_LEN-1:0] alu_result;
  logic alu_less, alu_zero;
  ysyx_23060025_rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_valid_i),
    .last (last_grant),
    .grant(g_hot),
    .idx  (g_idx),
    .any  (g_any)
  );
  ysyx_23060025_alu #(.DATA_LEN(DATA_LEN)) u_alu (
    .src1  (req_src1_i[int'(g_idx)*DATA_LEN +: DATA_LEN]),
    .src2  (req_src2_i[int'(g_idx)*DATA_LEN +: DATA_LEN]),
    .op    (req_op_i[int'(g_idx)*4 +: 4]),
    .result(alu_result),
    .less  (alu_less),
    .zero  (alu_zero)
  );
  // Only the owner's handshake frees the slot; ready never looks at request data
  assign can_accept = state == ARB_IDLE || rsp_ready_i[owner];
  assign req_ready_o = can_accept ? g_hot : '0;
  assign accept = g_any && can_accept;
  assign rsp_valid_o = state == ARB_RESP ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner : '0;
  always_comb state_nxt = accept ? ARB_RESP : (state == ARB_RESP && rsp_ready_i[owner]) ? ARB_IDLE : state;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      rsp_result_o <= '0;
      rsp_less_o <= 1'b0;
      rsp_zero_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= g_idx;
        last_grant <= g_idx;
        rsp_result_o <= alu_result;
        rsp_less_o <= alu_less;
        rsp_zero_o <= alu_zero;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_23060025_alu_arb.sv
// tb_ysyx_23060025_alu_arb: table-driven cycle vectors plus a reset-during-response sequence
module tb_ysyx_23060025_alu_arb;
  import ysyx_23060025_alu_arb_pkg::*;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [63:0] req_src1_i, req_src2_i;
  logic [7:0] req_op_i;
  logic [31:0] rsp_result_o;
  logic rsp_less_o, rsp_zero_o;
  int pass_cnt = 0, total = 0;
  ysyx_23060025_alu_arb #(.DATA_LEN(32), .NUM_REQ(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_src1_i(req_src1_i), .req_src2_i(req_src2_i), .req_op_i(req_op_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_less_o(rsp_less_o), .rsp_zero_o(rsp_zero_o)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [1:0] v, rr;
    logic [3:0] o0; logic [31:0] a0, b0;
    logic [3:0] o1; logic [31:0] a1, b1;
    logic [1:0] er, ev;
    logic [31:0] res;
    logic el, ez;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic [1:0] v, input logic [1:0] rr,
                     input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                     input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                     input logic [1:0] er, input logic [1:0] ev, input logic [31:0] res,
                     input logic el, input logic ez);
    vq.push_back('{v, rr, o0, a0, b0, o1, a1, b1, er, ev, res, el, ez});
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic drive(input logic [1:0] v, input logic [1:0] rr,
                       input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1);
    req_valid_i = v; rsp_ready_i = rr;
    req_op_i = {o1, o0}; req_src1_i = {a1, a0}; req_src2_i = {b1, b0};
  endtask
  task automatic check_rsp(input string tag, input logic [1:0] ev, input logic [31:0] res, input logic el, input logic ez);
    check({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'(ev));
    check({tag, " result"}, rsp_result_o, res);
    check({tag, " less"}, 32'(rsp_less_o), 32'(el));
    check({tag, " zero"}, 32'(rsp_zero_o), 32'(ez));
  endtask
  initial begin
    // both valid from reset: grant 0 then 1 back-to-back
    add(2'b11, 2'b11, ALU_OP_SUB, 3, 3, ALU_OP_XOR, 32'hF0, 32'h0F, 2'b01, 2'b00, 0, 0, 0);
    add(2'b10, 2'b11, ALU_OP_SUB, 3, 3, ALU_OP_XOR, 32'hF0, 32'h0F, 2'b10, 2'b01, 0, 0, 1);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'hFF, 0, 0);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hFF, 0, 0);
    // single ADD
    add(2'b01, 2'b11, ALU_OP_ADD, 5, 7, 0, 0, 0, 2'b01, 2'b00, 32'hFF, 0, 0);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 12, 1, 0);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 12, 1, 0);
    // signed vs unsigned compare
    add(2'b10, 2'b11, 0, 0, 0, ALU_OP_LESS_SIGNED, 32'hFFFFFFFF, 1, 2'b10, 2'b00, 12, 1, 0);
    add(2'b10, 2'b11, 0, 0, 0, ALU_OP_LESS_UNSIGNED, 32'hFFFFFFFF, 1, 2'b10, 2'b10, 1, 1, 0);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    // backpressure on owner 0, req1 waits
    add(2'b01, 2'b11, ALU_OP_ADD, 1, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0);
    add(2'b10, 2'b10, 0, 0, 0, ALU_OP_OR, 32'h30, 32'h0C, 2'b00, 2'b01, 2, 0, 1);
    add(2'b10, 2'b10, 0, 0, 0, ALU_OP_OR, 32'h30, 32'h0C, 2'b00, 2'b01, 2, 0, 1);
    add(2'b10, 2'b10, 0, 0, 0, ALU_OP_OR, 32'h30, 32'h0C, 2'b00, 2'b01, 2, 0, 1);
    add(2'b10, 2'b11, 0, 0, 0, ALU_OP_OR, 32'h30, 32'h0C, 2'b10, 2'b01, 2, 0, 1);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h3C, 0, 0);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h3C, 0, 0);
    // fairness: six back-to-back ops alternate 0,1,0,1,0,1
    add(2'b11, 2'b11, ALU_OP_ADD, 32'h10, 1, ALU_OP_SUB, 32'h20, 1, 2'b01, 2'b00, 32'h3C, 0, 0);
    for (int i = 0; i < 5; i++)
      add(2'b11, 2'b11, ALU_OP_ADD, 32'h10, 1, ALU_OP_SUB, 32'h20, 1,
          i % 2 ? 2'b01 : 2'b10, i % 2 ? 2'b10 : 2'b01, i % 2 ? 32'h1F : 32'h11, 0, 0);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h1F, 0, 0);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h1F, 0, 0);
    // undefined op gives 0, then SRA on req1
    add(2'b01, 2'b11, 4'd15, 4, 4, 0, 0, 0, 2'b01, 2'b00, 32'h1F, 0, 0);
    add(2'b10, 2'b11, 0, 0, 0, ALU_OP_SRA, 32'h80000000, 4, 2'b10, 2'b01, 0, 0, 1);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'hF8000000, 0, 0);
    add(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hF8000000, 0, 0);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check_rsp("reset", 2'b00, 0, 0, 0);
    check("reset req_ready", 32'(req_ready_o), 0);
    reset = 1'b0;
    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].rr, vq[i].o0, vq[i].a0, vq[i].b0, vq[i].o1, vq[i].a1, vq[i].b1);
      #1;
      check($sformatf("vec%0d req_ready", i), 32'(req_ready_o), 32'(vq[i].er));
      check_rsp($sformatf("vec%0d", i), vq[i].ev, vq[i].res, vq[i].el, vq[i].ez);
      @(posedge clock);
      #1;
    end
    // reset while owner 1 holds a response discards it and restores priority to req0
    drive(2'b10, 2'b00, 0, 0, 0, ALU_OP_ADD, 32'h55, 32'h55);
    #1;
    check("rst_seq grant1", 32'(req_ready_o), 32'(2'b10));
    @(posedge clock);
    #1;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    #1;
    check_rsp("rst_seq held", 2'b10, 32'hAA, 0, 1);
    @(posedge clock);
    #1;
    check_rsp("rst_seq still held", 2'b10, 32'hAA, 0, 1);
    reset = 1'b1;
    drive(2'b11, 2'b11, ALU_OP_SUB, 9, 4, ALU_OP_ADD, 32'h55, 32'h55);
    @(posedge clock);
    #1;
    check_rsp("rst_seq cleared", 2'b00, 0, 0, 0);
    reset = 1'b0;
    #1;
    check("rst_seq first grant", 32'(req_ready_o), 32'(2'b01));
    @(posedge clock);
    #1;
    check_rsp("rst_seq first rsp", 2'b01, 5, 0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/ysyx_23060025_alu_arb.md
Name: ysyx_23060025_alu_arb

Overview:
Shares one ALU instance between NUM_REQ requesters, e.g. EXU integer ops and LSU address generation. Uses round-robin arbitration with valid/ready request channels and a registered response. Only one operation is in flight at a time. Throughput is one op per cycle when the owner accepts its response immediately. Operand/opcode encoding is the existing ALU_OP_* set.

Parameters:
DATA_LEN, 32, operand/result width
NUM_REQ, 2, number of requesters (2..4)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  request valid, one bit per requester
req_ready_o  out  NUM_REQ  request accepted this cycle (one-hot or zero)
req_src1_i  in  NUM_REQ*DATA_LEN  operand 1, requester k at [k*DATA_LEN +: DATA_LEN]
req_src2_i  in  NUM_REQ*DATA_LEN  operand 2, same packing
req_op_i  in  NUM_REQ*4  ALU_OP_* code, requester k at [k*4 +: 4]
rsp_valid_o  out  NUM_REQ  response valid for owner (one-hot or zero)
rsp_ready_i  in  NUM_REQ  requester accepts response
rsp_result_o  out  DATA_LEN  ALU result, qualified by rsp_valid_o
rsp_less_o  out  1  ALU less/borrow flag
rsp_zero_o  out  1  ALU zero flag (src1 == src2)

Behaviour:
- Reset: state=IDLE, rsp_valid_o=0, rsp_result_o=0, rsp_less_o=0, rsp_zero_o=0, owner=0, last_grant=NUM_REQ-1 (requester 0 has top priority first).
- States:
  - IDLE: no response held.
  - RESP: response registered, waiting for the owner's rsp_ready_i.
- can_accept = (state==IDLE) | (state==RESP & rsp_ready_i[owner]).
- Grant (combinational):
  - Scan req_valid_i starting at last_grant+1, wrapping modulo NUM_REQ.
  - The first set bit is g.
  - req_ready_o[g] = can_accept; all other bits are 0.
  - req_ready_o depends combinationally on req_valid_i and rsp_ready_i. No combinational path from req_* data to req_ready_o.
- Accept (req_valid_i[g] & req_ready_o[g]):
  - The ALU evaluates the muxed src1/src2/op of g in the same cycle.
  - result/less/zero are registered at the clock edge.
  - owner<=g, last_grant<=g, state<=RESP.
  - rsp_valid_o[g]=1 in the next cycle. Latency is exactly 1 cycle, accept to response.
- RESP with rsp_ready_i[owner]=1 and no new accept: state<=IDLE, rsp_valid_o<=0. The registered result is held and not cleared.
- RESP with rsp_ready_i[owner]=0:
  - All registered outputs hold, bit-stable.
  - req_ready_o=0 for all requesters.
  - rsp_ready_i from non-owners is ignored.
- Simultaneous response handshake and new accept: the new response replaces the old one in the next cycle. It may go to a different owner. There is no idle bubble.
- last_grant updates only on accept, so a waiting requester is served within NUM_REQ accepts (no starvation).
- Requesters must hold valid and operands stable until ready. The arbiter does not check this; a dropped valid simply drops out of the next scan.
- Undefined op codes: result=0. less/zero flags are whatever the ALU produces. No error signalled.
- reset asserted in any state returns to the reset values at the next edge. Any pending response is discarded without a handshake.

Decomposition:
- Shared header ysyx_23060025_define.v holds:
  - ALU_OP_* codes (existing).
  - New ARB_IDLE/ARB_RESP state encodings (1 bit).
- Sub-modules:
  - The existing ALU is instantiated once.
  - The round-robin picker is a natural sub-module: ysyx_23060025_rr_pick, with inputs req vector and last_grant, and output one-hot grant plus index. It is reused by a future bus arbiter.

Test Plan:
1. After reset, only req0: ADD src1=5, src2=7 -> req_ready_o=01 in the same cycle; next cycle rsp_valid_o=01, result=12, zero=0. rsp_ready=1 -> IDLE.
2. req0 and req1 both valid from reset: req0 SUB 3-3, req1 XOR 0xF0^0x0F, both rsp_ready held 1 -> grants 0 then 1 back-to-back. Responses: result=0/zero=1, then result=0xFF, with no idle cycle between them.
3. req1 LESS_SIGNED src1=0xFFFFFFFF, src2=1 -> result=1, less=1. Then LESS_UNSIGNED with the same operands -> result=0, less=0.
4. Backpressure: accept req0 ADD 1+1, rsp_ready0=0 for 3 cycles while req1 is valid -> rsp_valid_o=01 and result=2 stable; req_ready_o=00 and rsp_ready1=1 has no effect. On the cycle rsp_ready0=1, req1 is accepted.
5. Fairness: req0 and req1 continuously valid, rsp_ready all 1, 6 ops -> grant sequence 0,1,0,1,0,1.
6. reset asserted during RESP holding rsp_valid_o=10 -> next cycle rsp_valid_o=00, outputs 0. The first post-reset grant goes to req0 when both are valid.
